// File: rtl/dma_read_arbiter.sv
// Round-robin arbiter sharing one weight-memory read port among the layer DMA requesters.
// Whole bursts are serialised: grant, issue to memory, stream beats back, then re-arbitrate.
module dma_read_arbiter #(
    parameter int unsigned N      = 3,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N*ADDR_W-1:0] req_addr,
    input  logic [N*LEN_W-1:0]  req_length,
    output logic [N-1:0]        ack,
    output logic [15:0]         dout,
    output logic [N-1:0]        dout_en,
    output logic [N-1:0]        dout_eop,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [LEN_W-1:0]    mem_length,
    input  logic                mem_ack,
    input  logic [15:0]         mem_dout,
    input  logic                mem_dout_en,
    input  logic                mem_dout_eop,
    output logic [1:0]          err
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StStream} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     prio_q, prio_d;
    logic [IdxW-1:0]     gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic [N-1:0]        ack_q, ack_d;
    logic [15:0]         dout_q, dout_d;
    logic [N-1:0]        dout_en_q, dout_en_d;
    logic [N-1:0]        dout_eop_q, dout_eop_d;
    logic [1:0]          err_q, err_d;

    logic [N-1:0]        eligible;
    logic                any_req;
    logic [IdxW-1:0]     sel;
    logic [IdxW-1:0]     cand;
    logic [N-1:0]        sel_oh;
    logic [N-1:0]        gnt_oh;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LEN_W-1:0]    sel_len;
    logic [LEN_W-1:0]    cnt_inc;

    function automatic logic [IdxW-1:0] next_slot(input logic [IdxW-1:0] s);
        return (32'(s) == N - 1) ? '0 : s + IdxW'(1);
    endfunction

    // A slot being acked this cycle still holds req; keep it out of the next search.
    always_comb begin
        eligible = req & ~ack_q;
        any_req  = 1'b0;
        sel      = '0;
        cand     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IdxW'((32'(prio_q) + k) % N);
            if (!any_req && eligible[cand]) begin
                any_req = 1'b1;
                sel     = cand;
            end
        end
    end

    assign sel_oh   = N'(1) << sel;
    assign gnt_oh   = N'(1) << gnt_q;
    assign sel_addr = req_addr[32'(sel)*ADDR_W +: ADDR_W];
    assign sel_len  = req_length[32'(sel)*LEN_W +: LEN_W];
    assign cnt_inc  = cnt_q + LEN_W'(1);

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        ack_d      = '0;
        dout_d     = dout_q;
        dout_en_d  = '0;
        dout_eop_d = '0;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    gnt_d  = sel;
                    addr_d = sel_addr;
                    len_d  = sel_len;
                    if (sel_len != '0) begin
                        mem_req_d = 1'b1;
                        state_d   = StIssue;
                    end else begin
                        // Empty burst: complete immediately without touching memory.
                        ack_d      = sel_oh;
                        dout_eop_d = sel_oh;
                        prio_d     = next_slot(sel);
                    end
                end
            end
            StIssue: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    ack_d     = gnt_oh;
                    cnt_d     = '0;
                    state_d   = StStream;
                end
            end
            StStream: begin
                if (mem_dout_en) begin
                    dout_d    = mem_dout;
                    dout_en_d = gnt_oh;
                    cnt_d     = cnt_inc;
                    if (cnt_inc > len_q) begin
                        err_d[0] = 1'b1;
                    end
                    if (mem_dout_eop) begin
                        dout_eop_d = gnt_oh;
                        if (cnt_inc != len_q) begin
                            err_d[0] = 1'b1;
                        end
                        prio_d  = next_slot(gnt_q);
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StStream && mem_dout_en) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            prio_q     <= '0;
            gnt_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            ack_q      <= '0;
            dout_q     <= '0;
            dout_en_q  <= '0;
            dout_eop_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
            dout_en_q  <= dout_en_d;
            dout_eop_q <= dout_eop_d;
            err_q      <= err_d;
        end
    end

    assign ack        = ack_q;
    assign dout       = dout_q;
    assign dout_en    = dout_en_q;
    assign dout_eop   = dout_eop_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = addr_q;
    assign mem_length = len_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dma_read_arbiter.sv
// Scoreboard bench for dma_read_arbiter: directed bursts push expected slot events,
// a forked monitor pops and compares whenever ack/dout_en/dout_eop is active.
module tb_dma_read_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*32-1:0] req_addr;
    logic [N*16-1:0] req_length;
    logic [N-1:0]  ack;
    logic [15:0]   dout;
    logic [N-1:0]  dout_en;
    logic [N-1:0]  dout_eop;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic [15:0]   mem_length;
    logic          mem_ack;
    logic [15:0]   mem_dout;
    logic          mem_dout_en;
    logic          mem_dout_eop;
    logic [1:0]    err;

    dma_read_arbiter #(.N(N), .ADDR_W(32), .LEN_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_addr     (req_addr),
        .req_length   (req_length),
        .ack          (ack),
        .dout         (dout),
        .dout_en      (dout_en),
        .dout_eop     (dout_eop),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_length   (mem_length),
        .mem_ack      (mem_ack),
        .mem_dout     (mem_dout),
        .mem_dout_en  (mem_dout_en),
        .mem_dout_eop (mem_dout_eop),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  ack;
        logic [2:0]  en;
        logic [2:0]  eop;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, req_v);
        end
    endtask

    function automatic void push_ev(input logic [2:0] a, input logic [2:0] en,
                                    input logic [2:0] eop, input logic [15:0] data);
        ev_t e;
        e.ack  = a;
        e.en   = en;
        e.eop  = eop;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if ((ack | dout_en | dout_eop) != 3'b000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output ack=%b en=%b eop=%b dout=%h",
                             ack, dout_en, dout_eop, dout);
                end else begin
                    e = exp_q.pop_front();
                    if (ack !== e.ack || dout_en !== e.en || dout_eop !== e.eop ||
                        (e.en != 3'b000 && dout !== e.data)) begin
                        errors++;
                        $display("FAIL sb_event got ack=%b en=%b eop=%b dout=%h required ack=%b en=%b eop=%b dout=%h",
                                 ack, dout_en, dout_eop, dout, e.ack, e.en, e.eop, e.data);
                    end
                end
            end
        end
    endtask

    task automatic set_slot(input int slot, input logic [31:0] addr, input logic [15:0] len);
        req_addr[slot*32 +: 32]   = addr;
        req_length[slot*16 +: 16] = len;
    endtask

    task automatic wait_mem_req();
        int waited = 0;
        do begin
            tick();
            waited++;
        end while (mem_req !== 1'b1 && waited < 8);
        check("mem_req_rise", {63'd0, mem_req}, 64'd1);
    endtask

    // Expects slot to be the next one granted; drives memory ack and beats.
    task automatic burst(input int slot, input logic [31:0] addr, input logic [15:0] len,
                         input int nbeats, input int ackdly, input logic [15:0] base);
        logic [2:0] oh;
        oh = 3'b001 << slot;
        wait_mem_req();
        check("mem_addr", {32'd0, mem_addr}, {32'd0, addr});
        check("mem_length", {48'd0, mem_length}, {48'd0, len});
        push_ev(oh, 3'b000, 3'b000, 16'h0);
        repeat (ackdly) tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        req[slot] = 1'b0;
        check("mem_req_drop", {63'd0, mem_req}, 64'd0);
        for (int i = 0; i < nbeats; i++) begin
            push_ev(3'b000, oh, (i == nbeats - 1) ? oh : 3'b000, base + 16'(i));
            mem_dout_en  = 1'b1;
            mem_dout     = base + 16'(i);
            mem_dout_eop = (i == nbeats - 1);
            tick();
        end
        mem_dout_en  = 1'b0;
        mem_dout_eop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "time limit");
    end

    initial begin
        rst          = 1'b1;
        req          = '0;
        req_addr     = '0;
        req_length   = '0;
        mem_ack      = 1'b0;
        mem_dout     = '0;
        mem_dout_en  = 1'b0;
        mem_dout_eop = 1'b0;
        fork
            monitor();
        join_none
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_ack", {61'd0, ack}, 64'd0);
        check("rst_dout_en", {61'd0, dout_en}, 64'd0);
        check("rst_dout_eop", {61'd0, dout_eop}, 64'd0);
        check("rst_dout", {48'd0, dout}, 64'd0);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        check("rst_mem_length", {48'd0, mem_length}, 64'd0);
        check("rst_err", {62'd0, err}, 64'd0);

        // Single request, slot 1
        set_slot(1, 32'h100, 16'd4);
        req[1] = 1'b1;
        burst(1, 32'h100, 16'd4, 4, 2, 16'h00A0);
        tick();
        check("single_err", {62'd0, err}, 64'd0);

        // Round-robin from prio 0: order 0,1,2,0
        do_reset();
        for (int s = 0; s < N; s++) set_slot(s, 32'h1000 * (s + 1), 16'd2);
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            burst(k % N, 32'h1000 * ((k % N) + 1), 16'd2, 2, k % 2, 16'h0100 * (k + 1));
            if (k < 3) req[k % N] = 1'b1;
            else req = '0;
        end
        tick();
        check("rr_err", {62'd0, err}, 64'd0);

        // Length mismatch: length 5, eop on beat 3; then a normal burst (prio now 1)
        set_slot(2, 32'h2000, 16'd5);
        req[2] = 1'b1;
        burst(2, 32'h2000, 16'd5, 3, 0, 16'h0300);
        check("mismatch_err", {62'd0, err}, 64'd1);
        set_slot(0, 32'h3000, 16'd1);
        req[0] = 1'b1;
        burst(0, 32'h3000, 16'd1, 1, 1, 16'h0400);
        tick();
        check("mismatch_sticky", {62'd0, err}, 64'd1);

        // Zero length on slot 2
        do_reset();
        set_slot(2, 32'h4000, 16'd0);
        req[2] = 1'b1;
        push_ev(3'b100, 3'b000, 3'b100, 16'h0);
        tick();
        req[2] = 1'b0;
        check("zero_mem_req", {63'd0, mem_req}, 64'd0);
        tick();
        check("zero_mem_req_after", {63'd0, mem_req}, 64'd0);
        tick();
        check("zero_err", {62'd0, err}, 64'd0);

        // Reset mid-stream: 2 of 8 beats, then reset, then late beats
        set_slot(1, 32'h5000, 16'd8);
        req[1] = 1'b1;
        wait_mem_req();
        push_ev(3'b010, 3'b000, 3'b000, 16'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        req[1]  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push_ev(3'b000, 3'b010, 3'b000, 16'h00B0 + 16'(i));
            mem_dout_en = 1'b1;
            mem_dout    = 16'h00B0 + 16'(i);
            tick();
        end
        rst      = 1'b1;
        mem_dout = 16'h00B2;
        tick();
        rst = 1'b0;
        check("midrst_ack", {61'd0, ack}, 64'd0);
        check("midrst_dout_en", {61'd0, dout_en}, 64'd0);
        check("midrst_dout", {48'd0, dout}, 64'd0);
        check("midrst_mem_req", {63'd0, mem_req}, 64'd0);
        check("midrst_mem_addr", {32'd0, mem_addr}, 64'd0);
        check("midrst_mem_length", {48'd0, mem_length}, 64'd0);
        for (int i = 3; i < 8; i++) begin
            mem_dout     = 16'h00B0 + 16'(i);
            mem_dout_eop = (i == 7);
            tick();
        end
        mem_dout_en  = 1'b0;
        mem_dout_eop = 1'b0;
        tick();
        check("midrst_err", {62'd0, err}, 64'd2);

        // Spurious data in IDLE, flag survives a later burst
        do_reset();
        mem_dout_en = 1'b1;
        mem_dout    = 16'hDEAD;
        tick();
        mem_dout_en = 1'b0;
        tick();
        check("spurious_err", {62'd0, err}, 64'd2);
        set_slot(0, 32'h6000, 16'd2);
        req[0] = 1'b1;
        burst(0, 32'h6000, 16'd2, 2, 1, 16'h00C0);
        tick();
        check("spurious_sticky", {62'd0, err}, 64'd2);

        repeat (3) tick();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
